// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-path definitions: datapath widths, PC step and the
// {pc, instr} entry carried through the instruction buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head entry, flush, and occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// capture into a small buffer, and redirect flush with stale-response dropping.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            run_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW:0]     credit_used;
    logic            accept;
    logic            resp_seen;
    logic            keep_resp;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Buffered plus in-flight entries must never exceed the buffer size, so a
    // response always has a slot to land in.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outst_q};
    assign imem_req_valid = run_q && !redirect_valid && !fifo_full
                            && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding belong to requests abandoned at reset.
    assign resp_seen  = imem_resp_valid && (outst_q != '0);
    assign keep_resp  = resp_seen && !redirect_valid && (drop_q == '0);
    assign pop        = instr_valid && instr_ready && !redirect_valid;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(accept) - CW'(resp_seen);
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            resp_pc_d  = align_pc(redirect_pc);
            drop_d     = outst_q - CW'(resp_seen);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_INC;
            end
            if (resp_seen) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + PC_INC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (keep_resp),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr_data  = head_entry.instr;
    assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: queue-based memory with programmable latency,
// plus a second instance at a high RESET_PC to exercise address wrap.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req_valid_hi;
    logic [31:0] addr_hi;
    logic        resp_valid_hi;
    logic [31:0] rdata_hi;
    logic        instr_valid_hi;
    logic [31:0] instr_data_hi;
    logic [31:0] instr_pc_hi;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int mem_lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_hi (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (req_valid_hi),
        .imem_req_ready  (1'b1),
        .imem_addr       (addr_hi),
        .imem_resp_valid (resp_valid_hi),
        .imem_rdata      (rdata_hi),
        .instr_valid     (instr_valid_hi),
        .instr_ready     (1'b1),
        .instr_data      (instr_data_hi),
        .instr_pc        (instr_pc_hi),
        .redirect_valid  (1'b0),
        .redirect_pc     (32'h0)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory: in-order, one response per cycle, mem_lat cycles after acceptance.
    initial begin
        imem_resp_valid = 1'b0;
        imem_rdata      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_addr, due: cyc + mem_lat});
            end
            @(posedge clk);
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_rdata      = word_at(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
        end
    end

    // Wrap-test memory: fixed one-cycle latency.
    initial begin
        logic        acc_hi;
        logic [31:0] a_hi;
        resp_valid_hi = 1'b0;
        rdata_hi      = '0;
        forever begin
            @(negedge clk);
            acc_hi = rst_n && req_valid_hi;
            a_hi   = addr_hi;
            @(posedge clk);
            #1;
            resp_valid_hi = acc_hi;
            rdata_hi      = word_at(a_hi);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        mem_lat        = lat;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_req_valid", imem_req_valid, 32'd0);
        check_eq("rst_instr_valid", instr_valid, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;
    endtask

    // Caller keeps instr_ready=1; the first presented entry is popped and checked.
    task automatic wait_instr(input string tag, input logic [31:0] pc_exp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                check_eq({tag, "_pc"}, instr_pc, pc_exp);
                check_eq({tag, "_data"}, instr_data, word_at(pc_exp));
                step();
                return;
            end
            step();
        end
        @(negedge clk);
        check_eq({tag, "_timeout"}, {31'b0, instr_valid}, 32'd1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;

        // Streaming after reset, 1-cycle memory; wrap on the high-RESET_PC instance.
        do_reset(1);
        for (int c = 1; c <= 6; c++) begin
            step();
            @(negedge clk);
            if (c == 1) begin
                check_eq("s1_first_req_valid", imem_req_valid, 32'd1);
                check_eq("s1_first_req_addr", imem_addr, 32'h0);
            end
            if (c == 2) check_eq("s1_latency_invalid", instr_valid, 32'd0);
            if (c >= 3) begin
                check_eq("s1_valid", instr_valid, 32'd1);
                check_eq("s1_pc", instr_pc, 32'((c - 3) * 4));
                check_eq("s1_data", instr_data, word_at(32'((c - 3) * 4)));
                check_eq("wrap_pc", instr_pc_hi, 32'hFFFF_FFF8 + 32'((c - 3) * 4));
                check_eq("wrap_data", instr_data_hi, word_at(32'hFFFF_FFF8 + 32'((c - 3) * 4)));
            end
        end

        // Decode stalled: buffer fills to exactly DEPTH, head holds at PC 0.
        do_reset(1);
        instr_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            @(negedge clk);
            if (c >= 3) check_eq("stall_head_pc", instr_pc, 32'h0);
        end
        check_eq("stall_req_valid", imem_req_valid, 32'd0);
        check_eq("stall_instr_valid", instr_valid, 32'd1);
        check_eq("stall_head_data", instr_data, word_at(32'h0));
        step();
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("drain_valid", instr_valid, 32'd1);
            check_eq("drain_pc", instr_pc, 32'(k * 4));
            step();
        end
        @(negedge clk);
        check_eq("drain_empty", instr_valid, 32'd0);

        // Memory backpressure: address held while not accepted.
        do_reset(1);
        step();
        step();
        step();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_addr", imem_addr, 32'h8);
            check_eq("bp_valid", imem_req_valid, 32'd1);
            step();
        end
        imem_req_ready = 1'b1;
        wait_instr("bp_next0", 32'h8);
        wait_instr("bp_next1", 32'hC);

        // Redirect with two requests outstanding (3-cycle memory).
        do_reset(3);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        check_eq("rd_req_blocked", imem_req_valid, 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("rd_new_addr", imem_addr, 32'h100);
        wait_instr("rd_first", 32'h100);
        wait_instr("rd_second", 32'h104);

        // Back-to-back redirects; second coincides with a response.
        do_reset(3);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_02F0;
        step();
        redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        check_eq("b2b_req_blocked", imem_req_valid, 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_addr", imem_addr, 32'h300);
        wait_instr("b2b_first", 32'h300);
        wait_instr("b2b_second", 32'h304);

        // Redirect in the same cycle as a response and a pop.
        do_reset(1);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        check_eq("same_head_valid", instr_valid, 32'd1);
        check_eq("same_head_pc", instr_pc, 32'h0);
        check_eq("same_resp_present", imem_resp_valid, 32'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("same_flushed", instr_valid, 32'd0);
        check_eq("same_addr", imem_addr, 32'h200);
        wait_instr("same_first", 32'h200);
        wait_instr("same_second", 32'h204);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
